// File: rtl/sha256_compress_iter.sv
// Iterative SHA-256 compression engine: one 512-bit block, 64 rounds at UNROLL
// rounds per clock, digest returned under a valid/ready handshake.
module sha256_compress_iter #(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] in_block,
    input  logic         in_first,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] out_digest,
    output logic         busy
);

    generate
        if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
            $fatal(1, "sha256_compress_iter: UNROLL must be 1, 2, 4 or 8");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    localparam logic [5:0] LAST_CNT = 6'(64 - UNROLL);
    localparam logic [5:0] STEP     = 6'(UNROLL);

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_s0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_s1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    state_t      state, state_next;
    logic [5:0]  cnt;
    logic [31:0] h_reg [8];
    logic [31:0] wv    [8];   // working variables, index 0 = a .. 7 = h
    logic [31:0] win   [16];  // schedule window, win[0] = W[cnt]
    logic [31:0] base  [8];
    logic [31:0] va    [8];
    logic [31:0] ww    [16];
    logic [31:0] t1, t2, w_new;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = ROUND;
            ROUND:   if (cnt == LAST_CNT) state_next = FINAL;
            FINAL:   state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_digest = {h_reg[0], h_reg[1], h_reg[2], h_reg[3],
                         h_reg[4], h_reg[5], h_reg[6], h_reg[7]};

    always_comb begin
        for (int i = 0; i < 8; i++) base[i] = in_first ? IV[i] : h_reg[i];
    end

    // UNROLL rounds chained combinationally; the window grows one word per round
    always_comb begin
        va    = wv;
        ww    = win;
        t1    = '0;
        t2    = '0;
        w_new = '0;
        for (int i = 0; i < UNROLL; i++) begin
            t1    = va[7] + big_s1(va[4]) + ch(va[4], va[5], va[6]) + K[cnt + 6'(i)] + ww[0];
            t2    = big_s0(va[0]) + maj(va[0], va[1], va[2]);
            w_new = small_s1(ww[14]) + ww[9] + small_s0(ww[1]) + ww[0];
            for (int j = 7; j > 0; j--) va[j] = va[j-1];
            va[4] = va[4] + t1;
            va[0] = t1 + t2;
            for (int j = 0; j < 15; j++) ww[j] = ww[j+1];
            ww[15] = w_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            for (int i = 0; i < 8; i++) begin
                h_reg[i] <= IV[i];
                wv[i]    <= IV[i];
            end
            for (int j = 0; j < 16; j++) win[j] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cnt <= '0;
                        for (int i = 0; i < 8; i++) begin
                            h_reg[i] <= base[i];
                            wv[i]    <= base[i];
                        end
                        for (int j = 0; j < 16; j++) win[j] <= in_block[511 - 32*j -: 32];
                    end
                end
                ROUND: begin
                    cnt <= cnt + STEP;
                    wv  <= va;
                    win <= ww;
                end
                FINAL: begin
                    for (int i = 0; i < 8; i++) h_reg[i] <= h_reg[i] + wv[i];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_compress_iter.sv
// Scoreboard bench for sha256_compress_iter: directed FIPS vectors, chaining,
// backpressure, mid-round reset and an UNROLL sweep on parallel instances.
module tb_sha256_compress_iter;

    localparam logic [511:0] ABC_BLK   = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [255:0] ABC_D     = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [511:0] EMPTY_BLK = {32'h80000000, {15{32'h0}}};
    localparam logic [255:0] EMPTY_D   = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [511:0] TWO_BLK1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                          32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                          32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                          32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] TWO_BLK2  = {{15{32'h0}}, 32'h000001c0};
    localparam logic [255:0] TWO_D     = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [255:0] IV_D      = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, in_first, out_valid, out_ready, busy;
    logic [511:0] in_block;
    logic [255:0] out_digest;

    logic         s_valid;
    logic [511:0] s_block;
    logic         s_in_ready  [3];
    logic         s_out_valid [3];
    logic [255:0] s_digest    [3];
    logic         s_busy      [3];

    typedef struct {
        logic [255:0] digest;
        bit           chk;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    bit   ov_prev = 1'b0;
    int   sw_acc = 0;
    bit   sw_pend [3] = '{0, 0, 0};
    bit   sw_prev [3] = '{0, 0, 0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sha256_compress_iter #(.UNROLL(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_block(in_block), .in_first(in_first), .out_valid(out_valid),
        .out_ready(out_ready), .out_digest(out_digest), .busy(busy));

    for (genvar k = 0; k < 3; k++) begin : g_sweep
        sha256_compress_iter #(.UNROLL(2 << k)) u_dut (
            .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s_in_ready[k]),
            .in_block(s_block), .in_first(1'b1), .out_valid(s_out_valid[k]),
            .out_ready(1'b1), .out_digest(s_digest[k]), .busy(s_busy[k]));
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor for the UNROLL=1 instance: every rising out_valid pops one expectation
    always @(negedge clk) begin
        exp_t e;
        if (out_valid && !ov_prev) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 256'(out_valid), 256'(0));
            end else begin
                e = sb.pop_front();
                check("latency_u1", 256'(cyc - e.acc), 256'(65));
                if (e.chk) check("digest_u1", out_digest, e.digest);
            end
        end
        ov_prev = out_valid;
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (s_out_valid[k] && !sw_prev[k]) begin
                if (!sw_pend[k]) begin
                    check("unexpected_sweep_valid", 256'(k), 256'(99));
                end else begin
                    sw_pend[k] = 1'b0;
                    check("latency_sweep", 256'(cyc - sw_acc), 256'(64 / (2 << k) + 1));
                    check("digest_sweep", s_digest[k], ABC_D);
                end
            end
            sw_prev[k] = s_out_valid[k];
        end
    end

    task automatic send(input logic [511:0] blk, input logic first, input bit chk, input logic [255:0] exp);
        exp_t e;
        int   guard = 0;
        in_block = blk;
        in_first = first;
        in_valid = 1'b1;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) check("wait_in_ready", 256'(in_ready), 256'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        e.digest = exp;
        e.chk    = chk;
        e.acc    = cyc;
        sb.push_back(e);
    endtask

    task automatic wait_valid();
        int guard = 0;
        while (!out_valid && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!out_valid) check("wait_out_valid", 256'(out_valid), 256'(1));
    endtask

    task automatic run_block(input logic [511:0] blk, input logic first, input bit chk, input logic [255:0] exp);
        send(blk, first, chk, exp);
        wait_valid();
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_block = '0; in_first = 1'b0; out_ready = 1'b1;
        s_valid = 1'b0; s_block = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready", 256'(in_ready), 256'(1));
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_digest", out_digest, IV_D);

        // "abc" with the consumer stalling, while upstream offers another block
        out_ready = 1'b0;
        send(ABC_BLK, 1'b1, 1'b1, ABC_D);
        wait_valid();
        in_block = EMPTY_BLK; in_first = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold_out_valid", 256'(out_valid), 256'(1));
            check("hold_digest", out_digest, ABC_D);
            check("hold_in_ready", 256'(in_ready), 256'(0));
            check("hold_busy", 256'(busy), 256'(1));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_out_valid", 256'(out_valid), 256'(0));
        check("release_in_ready", 256'(in_ready), 256'(1));
        check("release_digest", out_digest, ABC_D);
        @(posedge clk); #1;
        check("idle_stays_idle", 256'(busy), 256'(0));

        run_block(EMPTY_BLK, 1'b1, 1'b1, EMPTY_D);
        run_block(TWO_BLK1, 1'b1, 1'b0, '0);
        run_block(TWO_BLK2, 1'b0, 1'b1, TWO_D);

        // Reset with the round counter at 30
        send(ABC_BLK, 1'b1, 1'b1, ABC_D);
        repeat (30) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        check("midrst_out_valid", 256'(out_valid), 256'(0));
        check("midrst_busy", 256'(busy), 256'(0));
        check("midrst_digest", out_digest, IV_D);
        check("midrst_in_ready", 256'(in_ready), 256'(1));
        run_block(ABC_BLK, 1'b0, 1'b1, ABC_D);

        // UNROLL sweep: all three instances accept on the same edge
        s_block = ABC_BLK;
        s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        sw_acc = cyc;
        for (int k = 0; k < 3; k++) sw_pend[k] = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++)
            if (sw_pend[k]) check("sweep_timeout", 256'(k), 256'(99));

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
